display_scanner: RTL and testbench
==================================

DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 50000, NEclk cycles each digit stays lit (1 kHz per digit at 50 MHz).
REQ-002 NEclk  input  1  system clock; all state updates on its falling edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 bcd_h_1, bcd_h_0, bcd_min_1, bcd_min_0, bcd_s_1, bcd_s_0  input  4 each  stopwatch BCD digits from the counter stage.
REQ-005 bcd_ms_2, bcd_ms_1, bcd_ms_0  input  4 each  millisecond BCD digits (hundreds, tens, units).
REQ-006 page_btn  input  1  page-advance request, level, already debounced.
REQ-007 lap_btn  input  1  lap hold toggle, level, already debounced.
REQ-008 seg  output  7  segments g..a, active-low.
REQ-009 dp  output  1  decimal point, active-low.
REQ-010 an  output  4  digit enables, active-low; an[0] is the rightmost digit.
REQ-011 page  output  2  current page number.
REQ-012 hold  output  1  high while the display is frozen by lap.

Function
REQ-013 page_btn and lap_btn SHALL be registered once; an event is a 0->1 transition of the registered value (one event per press).
REQ-014 A page event SHALL advance page 0->1->2->0 in the next cycle.
REQ-015 A lap event SHALL toggle hold in the next cycle; on hold 0->1 all nine input digits SHALL be copied into snapshot registers in that same cycle.
REQ-016 Displayed digits SHALL be the snapshot while hold=1, otherwise the live inputs.
REQ-017 Simultaneous page and lap events SHALL both take effect in the same cycle.
REQ-018 Page 0 (digit 3..0): h_1 h_0 min_1 min_0, dp lit on digit 2.
REQ-019 Page 1: min_1 min_0 s_1 s_0, dp lit on digit 2.
REQ-020 Page 2: s_0 ms_2 ms_1 ms_0, dp lit on digit 3.
REQ-021 On page 0, digit 3 SHALL be blank (seg=7'h7F) when h_1=0.
REQ-022 Any digit value 10..15 SHALL display a dash (only segment g lit, seg=7'h3F).
REQ-023 A prescaler SHALL count 0..SCAN_DIV-1; at terminal count the digit pointer SHALL advance 0->1->2->3->0 (wrap).
REQ-024 an, seg and dp SHALL be registered: one cycle after the pointer or page changes, they SHALL reflect the new pointer/page; exactly one an bit low outside reset.
REQ-025 A page change SHALL NOT reset the pointer or prescaler.

Reset
REQ-026 While reset=1: an=4'hF, seg=7'h7F, dp=1, page=0, hold=0, pointer=0, prescaler=0, edge registers=0, snapshot=0.
REQ-027 Reset SHALL dominate page/lap events in the same cycle; a button held through reset release SHALL NOT produce an event.
REQ-028 First cycle after reset release: an=4'b1110 showing page 0 digit 0.

Structure
REQ-029 Segment code constants (digits 0-9, blank, dash) and page encodings SHALL live in a shared stopwatch constants package/include.
REQ-030 Digit-to-segment decoding SHALL be a combinational sub-module bcd_to_7seg (4-bit in, 7-bit active-low out, dash for >9).
REQ-031 Prescaler width SHALL be derived from SCAN_DIV via $clog2.

Verification (SCAN_DIV=4)
REQ-032 Reset, inputs 12:34:56.789 -> an cycles 1110,1101,1011,0111 every 4 cycles; seg shows 4,3,2,1; dp low only with an=1011.
REQ-033 One page pulse then 2nd pulse -> page=1 shows 3,4,5,6 (digits 3..0); page=2 shows 6,7,8,9 with dp on digit 3; third pulse returns page=0.
REQ-034 Lap pulse at 00:00:01.250, then inputs run to 00:00:03.000 -> page 2 still shows 1,2,5,0, hold=1; second lap pulse -> shows 3,0,0,0, hold=0.
REQ-035 h_1=0, h_0=7 on page 0 -> digit 3 seg=7'h7F; force min_0=4'hB -> digit 0 seg=7'h3F.
REQ-036 page_btn and lap_btn rise same cycle -> page and hold both change next cycle; assert reset mid-scan with button high -> all outputs at reset values, no event after release until button falls and rises again.

Source files
------------

// File: rtl/display_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_scanner_pkg
// Description : Shared stopwatch display constants: active-low segment codes
//               (g..a), page encodings, digit bundle type and page stepping.
// Revision    : 1.0 - initial release
// ============================================================================
package display_scanner_pkg;

    // Segment codes, bit 6 = g ... bit 0 = a, active-low
    localparam logic [6:0] c_seg_0     = 7'h40;
    localparam logic [6:0] c_seg_1     = 7'h79;
    localparam logic [6:0] c_seg_2     = 7'h24;
    localparam logic [6:0] c_seg_3     = 7'h30;
    localparam logic [6:0] c_seg_4     = 7'h19;
    localparam logic [6:0] c_seg_5     = 7'h12;
    localparam logic [6:0] c_seg_6     = 7'h02;
    localparam logic [6:0] c_seg_7     = 7'h78;
    localparam logic [6:0] c_seg_8     = 7'h00;
    localparam logic [6:0] c_seg_9     = 7'h10;
    localparam logic [6:0] c_seg_blank = 7'h7F;
    localparam logic [6:0] c_seg_dash  = 7'h3F;

    // Display pages
    localparam logic [1:0] c_page_0 = 2'd0;  // hh:mm
    localparam logic [1:0] c_page_1 = 2'd1;  // mm:ss
    localparam logic [1:0] c_page_2 = 2'd2;  // s.mmm

    // All nine stopwatch digits as one bundle (live or snapshot)
    typedef struct packed {
        logic [3:0] h_1;
        logic [3:0] h_0;
        logic [3:0] min_1;
        logic [3:0] min_0;
        logic [3:0] s_1;
        logic [3:0] s_0;
        logic [3:0] ms_2;
        logic [3:0] ms_1;
        logic [3:0] ms_0;
    } digits_t;

    // Page sequence 0 -> 1 -> 2 -> 0
    function automatic logic [1:0] next_page(input logic [1:0] cur);
        return (cur == c_page_2) ? c_page_0 : cur + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_to_7seg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_7seg
// Description : Combinational BCD digit to active-low 7-segment decoder;
//               non-decimal codes 10..15 render as a dash.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_7seg
    import display_scanner_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Table lookup; anything above 9 shows only segment g
    always_comb begin
        o_seg = c_seg_dash;
        case (i_bcd)
            4'd0:    o_seg = c_seg_0;
            4'd1:    o_seg = c_seg_1;
            4'd2:    o_seg = c_seg_2;
            4'd3:    o_seg = c_seg_3;
            4'd4:    o_seg = c_seg_4;
            4'd5:    o_seg = c_seg_5;
            4'd6:    o_seg = c_seg_6;
            4'd7:    o_seg = c_seg_7;
            4'd8:    o_seg = c_seg_8;
            4'd9:    o_seg = c_seg_9;
            default: o_seg = c_seg_dash;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : display_scanner
// Description : Four-digit multiplexed stopwatch display with three pages
//               and a lap hold that freezes a snapshot of all digits.
//               All state advances on the falling edge of NEclk.
// Revision    : 1.0 - initial release
// ============================================================================
module display_scanner
    import display_scanner_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic       NEclk,
    input  logic       reset,
    input  logic [3:0] bcd_h_1,
    input  logic [3:0] bcd_h_0,
    input  logic [3:0] bcd_min_1,
    input  logic [3:0] bcd_min_0,
    input  logic [3:0] bcd_s_1,
    input  logic [3:0] bcd_s_0,
    input  logic [3:0] bcd_ms_2,
    input  logic [3:0] bcd_ms_1,
    input  logic [3:0] bcd_ms_0,
    input  logic       page_btn,
    input  logic       lap_btn,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic [1:0] page,
    output logic       hold
);

    localparam int                   c_presc_w    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(SCAN_DIV - 1);

    logic                 r_page_sync, r_page_prev;
    logic                 r_lap_sync,  r_lap_prev;
    logic                 r_armed;
    logic [1:0]           r_page;
    logic                 r_hold;
    digits_t              r_snap;
    logic [c_presc_w-1:0] r_presc;
    logic [1:0]           r_ptr;
    logic [3:0]           r_an;
    logic [6:0]           r_seg;
    logic                 r_dp;

    digits_t              w_live;
    digits_t              w_disp;
    logic [3:0]           w_digit;
    logic                 w_blank;
    logic                 w_dp_on;
    logic [6:0]           w_seg_dec;
    logic                 w_page_evt;
    logic                 w_lap_evt;

    assign w_live = '{h_1: bcd_h_1, h_0: bcd_h_0, min_1: bcd_min_1, min_0: bcd_min_0,
                      s_1: bcd_s_1, s_0: bcd_s_0, ms_2: bcd_ms_2, ms_1: bcd_ms_1,
                      ms_0: bcd_ms_0};

    assign w_page_evt = r_page_sync & ~r_page_prev;
    assign w_lap_evt  = r_lap_sync  & ~r_lap_prev;

    // Button registers; on the first cycle out of reset the history bit is
    // loaded with the raw level so a button held through reset is not an edge
    always_ff @(negedge NEclk) begin
        if (reset) begin
            r_page_sync <= 1'b0;
            r_page_prev <= 1'b0;
            r_lap_sync  <= 1'b0;
            r_lap_prev  <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_page_sync <= page_btn;
            r_lap_sync  <= lap_btn;
            r_page_prev <= r_armed ? r_page_sync : page_btn;
            r_lap_prev  <= r_armed ? r_lap_sync  : lap_btn;
            r_armed     <= 1'b1;
        end
    end

    // Page stepping, lap hold toggle and snapshot capture on hold entry
    always_ff @(negedge NEclk) begin
        if (reset) begin
            r_page <= c_page_0;
            r_hold <= 1'b0;
            r_snap <= '0;
        end else begin
            if (w_page_evt) begin
                r_page <= next_page(r_page);
            end
            if (w_lap_evt) begin
                r_hold <= ~r_hold;
                if (!r_hold) begin
                    r_snap <= w_live;
                end
            end
        end
    end

    // Scan prescaler and digit pointer; independent of page changes
    always_ff @(negedge NEclk) begin
        if (reset) begin
            r_presc <= '0;
            r_ptr   <= 2'd0;
        end else if (r_presc == c_presc_last) begin
            r_presc <= '0;
            r_ptr   <= r_ptr + 2'd1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Select the digit, blanking and decimal point for the current pointer/page
    always_comb begin
        w_disp  = r_hold ? r_snap : w_live;
        w_digit = w_disp.min_0;
        w_blank = 1'b0;
        w_dp_on = 1'b0;
        case (r_page)
            c_page_1: begin
                case (r_ptr)
                    2'd0:    w_digit = w_disp.s_0;
                    2'd1:    w_digit = w_disp.s_1;
                    2'd2:    w_digit = w_disp.min_0;
                    default: w_digit = w_disp.min_1;
                endcase
                w_dp_on = (r_ptr == 2'd2);
            end
            c_page_2: begin
                case (r_ptr)
                    2'd0:    w_digit = w_disp.ms_0;
                    2'd1:    w_digit = w_disp.ms_1;
                    2'd2:    w_digit = w_disp.ms_2;
                    default: w_digit = w_disp.s_0;
                endcase
                w_dp_on = (r_ptr == 2'd3);
            end
            default: begin
                case (r_ptr)
                    2'd0:    w_digit = w_disp.min_0;
                    2'd1:    w_digit = w_disp.min_1;
                    2'd2:    w_digit = w_disp.h_0;
                    default: w_digit = w_disp.h_1;
                endcase
                // Suppress the leading hours zero
                w_blank = (r_ptr == 2'd3) && (w_disp.h_1 == 4'd0);
                w_dp_on = (r_ptr == 2'd2);
            end
        endcase
    end

    bcd_to_7seg u_dec (
        .i_bcd (w_digit),
        .o_seg (w_seg_dec)
    );

    // Registered drive of the display pins
    always_ff @(negedge NEclk) begin
        if (reset) begin
            r_an  <= 4'hF;
            r_seg <= c_seg_blank;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= ~(4'b0001 << r_ptr);
            r_seg <= w_blank ? c_seg_blank : w_seg_dec;
            r_dp  <= ~w_dp_on;
        end
    end

    assign an   = r_an;
    assign seg  = r_seg;
    assign dp   = r_dp;
    assign page = r_page;
    assign hold = r_hold;

endmodule
`default_nettype wire

// File: tb/tb_display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scanner
// Description : Directed self-checking bench for display_scanner (SCAN_DIV=4)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scanner;

    // Hand-written active-low segment patterns (g..a)
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] SD = 7'b0111111;

    logic       NEclk = 1'b0;
    logic       reset;
    logic [3:0] bcd_h_1, bcd_h_0, bcd_min_1, bcd_min_0, bcd_s_1, bcd_s_0;
    logic [3:0] bcd_ms_2, bcd_ms_1, bcd_ms_0;
    logic       page_btn, lap_btn;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic [1:0] page;
    logic       hold;

    int checks = 0;
    int errors = 0;

    display_scanner #(.SCAN_DIV(4)) dut (
        .NEclk     (NEclk),
        .reset     (reset),
        .bcd_h_1   (bcd_h_1),
        .bcd_h_0   (bcd_h_0),
        .bcd_min_1 (bcd_min_1),
        .bcd_min_0 (bcd_min_0),
        .bcd_s_1   (bcd_s_1),
        .bcd_s_0   (bcd_s_0),
        .bcd_ms_2  (bcd_ms_2),
        .bcd_ms_1  (bcd_ms_1),
        .bcd_ms_0  (bcd_ms_0),
        .page_btn  (page_btn),
        .lap_btn   (lap_btn),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .page      (page),
        .hold      (hold)
    );

    always #5 NEclk = ~NEclk;

    // Advance n falling edges, then settle 1 time unit past the edge
    task automatic step(input int n);
        repeat (n) begin
            @(negedge NEclk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bounded wait for a given digit enable, then check it was reached
    task automatic wait_an(input logic [3:0] want);
        int n = 0;
        while (an !== want && n < 20) begin
            step(1);
            n++;
        end
        check("an_reach", {28'd0, an}, {28'd0, want});
    endtask

    task automatic digit(input string tag, input logic [3:0] want_an,
                         input logic [6:0] want_seg, input logic want_dp);
        wait_an(want_an);
        check(tag, {24'd0, seg, dp}, {24'd0, want_seg, want_dp});
    endtask

    task automatic set_time(input logic [3:0] h1, h0, m1, m0, s1, s0, ms2, ms1, ms0);
        bcd_h_1 = h1; bcd_h_0 = h0; bcd_min_1 = m1; bcd_min_0 = m0;
        bcd_s_1 = s1; bcd_s_0 = s0; bcd_ms_2 = ms2; bcd_ms_1 = ms1; bcd_ms_0 = ms0;
    endtask

    task automatic page_pulse();
        page_btn = 1'b1;
        step(2);
        page_btn = 1'b0;
        step(2);
    endtask

    task automatic lap_pulse();
        lap_btn = 1'b1;
        step(2);
        lap_btn = 1'b0;
        step(2);
    endtask

    initial begin
        reset    = 1'b1;
        page_btn = 1'b0;
        lap_btn  = 1'b0;
        set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9);
        step(3);
        check("rst_an",   {28'd0, an},   32'hF);
        check("rst_seg",  {25'd0, seg},  32'h7F);
        check("rst_dp",   {31'd0, dp},   32'h1);
        check("rst_page", {30'd0, page}, 32'h0);
        check("rst_hold", {31'd0, hold}, 32'h0);

        // First scan after release: exact 4-cycle cadence, page 0 = 12.34
        reset = 1'b0;
        step(1);
        check("scan0_an", {28'd0, an}, 32'hE);
        check("scan0_sd", {24'd0, seg, dp}, {24'd0, S4, 1'b1});
        step(3);
        check("scan0_hold_an", {28'd0, an}, 32'hE);
        step(1);
        check("scan1_an", {28'd0, an}, 32'hD);
        check("scan1_sd", {24'd0, seg, dp}, {24'd0, S3, 1'b1});
        step(4);
        check("scan2_an", {28'd0, an}, 32'hB);
        check("scan2_sd", {24'd0, seg, dp}, {24'd0, S2, 1'b0});
        step(4);
        check("scan3_an", {28'd0, an}, 32'h7);
        check("scan3_sd", {24'd0, seg, dp}, {24'd0, S1, 1'b1});
        step(4);
        check("scan_wrap_an", {28'd0, an}, 32'hE);

        // Page event: one cycle to register, next cycle page moves; held button is one event
        page_btn = 1'b1;
        step(1);
        check("pg_lat0", {30'd0, page}, 32'h0);
        step(1);
        check("pg_step1", {30'd0, page}, 32'h1);
        step(3);
        check("pg_held", {30'd0, page}, 32'h1);
        page_btn = 1'b0;
        step(2);
        digit("p1_d3", 4'b0111, S3, 1'b1);
        digit("p1_d2", 4'b1011, S4, 1'b0);
        digit("p1_d1", 4'b1101, S5, 1'b1);
        digit("p1_d0", 4'b1110, S6, 1'b1);

        page_pulse();
        check("pg_step2", {30'd0, page}, 32'h2);
        digit("p2_d3", 4'b0111, S6, 1'b0);
        digit("p2_d2", 4'b1011, S7, 1'b1);
        digit("p2_d1", 4'b1101, S8, 1'b1);
        digit("p2_d0", 4'b1110, S9, 1'b1);

        page_pulse();
        check("pg_wrap", {30'd0, page}, 32'h0);

        // Lap hold on page 2
        page_pulse();
        page_pulse();
        check("pg_back2", {30'd0, page}, 32'h2);
        set_time(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd5, 4'd0);
        lap_pulse();
        check("lap_on", {31'd0, hold}, 32'h1);
        set_time(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd3, 4'd0, 4'd0, 4'd0);
        step(1);
        digit("snap_d3", 4'b0111, S1, 1'b0);
        digit("snap_d2", 4'b1011, S2, 1'b1);
        digit("snap_d1", 4'b1101, S5, 1'b1);
        digit("snap_d0", 4'b1110, S0, 1'b1);
        check("lap_still", {31'd0, hold}, 32'h1);
        lap_pulse();
        check("lap_off", {31'd0, hold}, 32'h0);
        digit("live_d3", 4'b0111, S3, 1'b0);
        digit("live_d2", 4'b1011, S0, 1'b1);

        // Leading-zero blank and dash on page 0
        page_pulse();
        check("pg_to0", {30'd0, page}, 32'h0);
        set_time(4'd0, 4'd7, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9);
        step(1);
        digit("blank_d3", 4'b0111, SB, 1'b1);
        digit("h0_d2",    4'b1011, S7, 1'b0);
        bcd_min_0 = 4'hB;
        digit("dash_d0",  4'b1110, SD, 1'b1);

        // Simultaneous page and lap events
        page_btn = 1'b1;
        lap_btn  = 1'b1;
        step(1);
        check("sim_pg_pre",   {30'd0, page}, 32'h0);
        check("sim_hold_pre", {31'd0, hold}, 32'h0);
        step(1);
        check("sim_pg",   {30'd0, page}, 32'h1);
        check("sim_hold", {31'd0, hold}, 32'h1);
        page_btn = 1'b0;
        lap_btn  = 1'b0;
        step(5);

        // Reset mid-scan with page button raised in the same cycle
        reset    = 1'b1;
        page_btn = 1'b1;
        step(2);
        check("mrst_an",   {28'd0, an},   32'hF);
        check("mrst_seg",  {25'd0, seg},  32'h7F);
        check("mrst_dp",   {31'd0, dp},   32'h1);
        check("mrst_page", {30'd0, page}, 32'h0);
        check("mrst_hold", {31'd0, hold}, 32'h0);
        reset = 1'b0;
        step(1);
        check("mrst_an_rel", {28'd0, an}, 32'hE);
        step(4);
        check("held_no_evt", {30'd0, page}, 32'h0);
        page_btn = 1'b0;
        step(2);
        check("fall_no_evt", {30'd0, page}, 32'h0);
        page_btn = 1'b1;
        step(2);
        check("new_press", {30'd0, page}, 32'h1);
        page_btn = 1'b0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
